// File: rtl/read_data_assembler.sv
// -----------------------------------------------------------------------------
// read_data_assembler
//
// Packs one DDR3 read burst into a single wide word for the CPU side.
// After a READ command is accepted, the block waits the latched CAS-style
// latency and then shifts in NW = BL/2 capture words, first word in the LSBs.
// The assembled word goes into a 2-entry fall-through FIFO that is drained
// with a valid/ready handshake.
//
// Ports:
//   clock        - single rising-edge clock
//   reset        - asynchronous, active-high; clears all state
//   rd_issue     - one-cycle READ command pulse
//   rd_latency   - cycles from rd_issue to first capture (0 behaves as 1)
//   burst_data   - 2*BW-bit word from the read-burst capture stage
//   rd_ready     - a new rd_issue can be accepted this cycle
//   cpu_rdata    - assembled burst at the FIFO head
//   cpu_rvalid   - FIFO non-empty
//   cpu_rready   - CPU accepts the head entry
//   busy         - a burst is in flight (waiting or capturing)
//   protocol_err - sticky: rd_issue seen while rd_ready was low
// -----------------------------------------------------------------------------
module read_data_assembler #(
    parameter int BW  = 8,
    parameter int BL  = 8,
    parameter int CLW = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               rd_issue,
    input  logic [CLW-1:0]     rd_latency,
    input  logic [2*BW-1:0]    burst_data,
    output logic               rd_ready,
    output logic [BW*BL-1:0]   cpu_rdata,
    output logic               cpu_rvalid,
    input  logic               cpu_rready,
    output logic               busy,
    output logic               protocol_err
);

    localparam int WW = 2 * BW;                       // capture word width
    localparam int NW = BL / 2;                       // captures per burst
    localparam int DW = BW * BL;                      // assembled word width
    localparam int KW = (NW > 1) ? $clog2(NW) : 1;    // word index width

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT_CL = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]     state_q,    state_d;
    logic [CLW-1:0] lat_cnt_q,  lat_cnt_d;
    logic [KW-1:0]  word_idx_q, word_idx_d;
    logic [DW-1:0]  asm_q,      asm_d;
    logic           perr_q,     perr_d;

    logic           wr_ptr_q,   wr_ptr_d;
    logic           rd_ptr_q,   rd_ptr_d;
    logic [1:0]     count_q,    count_d;

    logic           issue_accept;
    logic           push;
    logic           pop;
    logic [CLW-1:0] lat_eff;

    // ------------------------------------------------------------------
    // Handshake / status
    // ------------------------------------------------------------------
    // Only one burst is ever in flight and a new one is only accepted while
    // the FIFO has a free slot, so a push can never overflow the FIFO.
    assign rd_ready     = (state_q == S_IDLE) && (count_q < 2'd2);
    assign issue_accept = rd_issue && rd_ready;
    assign busy         = (state_q != S_IDLE);
    assign cpu_rvalid   = (count_q != 2'd0);
    assign pop          = cpu_rvalid && cpu_rready;
    assign protocol_err = perr_q;

    // A programmed latency of zero is treated as one cycle.
    assign lat_eff = (rd_latency == '0) ? CLW'(1) : rd_latency;

    // ------------------------------------------------------------------
    // Burst FSM and assembly register
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        lat_cnt_d  = lat_cnt_q;
        word_idx_d = word_idx_q;
        asm_d      = asm_q;
        push       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (issue_accept) begin
                    // Counter holds the cycles still to wait before the
                    // capture state; latency 1 skips the wait entirely.
                    lat_cnt_d  = lat_eff - CLW'(1);
                    word_idx_d = '0;
                    state_d    = (lat_eff == CLW'(1)) ? S_CAPTURE : S_WAIT_CL;
                end
            end

            S_WAIT_CL: begin
                lat_cnt_d = lat_cnt_q - CLW'(1);
                if (lat_cnt_d == '0) begin
                    state_d = S_CAPTURE;
                end
            end

            S_CAPTURE: begin
                // Word k lands in slice k; constant slices keep the mux simple.
                for (int k = 0; k < NW; k++) begin
                    if (word_idx_q == KW'(k)) begin
                        asm_d[k*WW +: WW] = burst_data;
                    end
                end
                if (word_idx_q == KW'(NW - 1)) begin
                    // asm_d already contains the final word, so it is the
                    // value written into the FIFO this edge.
                    push       = 1'b1;
                    word_idx_d = '0;
                    state_d    = S_IDLE;
                end else begin
                    word_idx_d = word_idx_q + KW'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sticky error: any READ presented while not ready is dropped and flagged.
    always_comb begin
        perr_d = perr_q | (rd_issue & ~rd_ready);
    end

    // ------------------------------------------------------------------
    // FIFO pointers and occupancy
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d = pop  ? ~rd_ptr_q : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;     // idle, or push+pop cancels out
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            lat_cnt_q  <= '0;
            word_idx_q <= '0;
            asm_q      <= '0;
            perr_q     <= 1'b0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            state_q    <= state_d;
            lat_cnt_q  <= lat_cnt_d;
            word_idx_q <= word_idx_d;
            asm_q      <= asm_d;
            perr_q     <= perr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage: one register per entry
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            logic [DW-1:0] data_q;
            logic [DW-1:0] data_d;

            always_comb begin
                data_d = data_q;
                if (push && (wr_ptr_q == 1'(gi))) begin
                    data_d = asm_d;
                end
            end

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    data_q <= '0;
                end else begin
                    data_q <= data_d;
                end
            end
        end
    endgenerate

    // Fall-through head. While the FIFO is empty this shows a stale entry,
    // which the CPU side must ignore; after reset both entries read as zero.
    assign cpu_rdata = rd_ptr_q ? g_entry[1].data_q : g_entry[0].data_q;

endmodule
